cpu_insfetch: RTL and testbench
===============================

CPU_INSFETCH -- requirements
Module: cpu_insfetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (32 or 64).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 2, instruction buffer entries and maximum outstanding requests (power of two, at least 2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 SHALL have port imem_rsp_valid  input  1  response valid, in order, always accepted.
REQ-010 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-011 SHALL have port imem_rsp_err  input  1  access fault for this response.
REQ-012 SHALL have port instr_valid  output  1  buffer head valid toward decoder.
REQ-013 SHALL have port instr_ready  input  1  decoder consumes head.
REQ-014 SHALL have port instr  output  32  instruction word for cpu_insdecode.
REQ-015 SHALL have port instr_pc  output  XLEN  address of instr.
REQ-016 SHALL have port instr_fault  output  1  head entry carries an access fault.
REQ-017 SHALL have port redirect_valid  input  1  flush and restart fetch.
REQ-018 SHALL have port redirect_pc  input  XLEN  restart address.

Function
REQ-019 SHALL implement states RUN and HALT; reset state is RUN.
REQ-020 SHALL hold fetch_pc, outstanding count, discard count, and a DEPTH-entry FIFO of {instr, pc, fault}.
REQ-021 SHALL assert imem_req_valid only when all hold: state is RUN, redirect_valid is 0, and outstanding + FIFO occupancy < DEPTH.
REQ-022 SHALL drive imem_req_addr = fetch_pc.
REQ-023 SHALL keep imem_req_valid and imem_req_addr stable until handshake unless redirect_valid rises.
REQ-024 SHALL, on a request handshake (valid & ready), advance fetch_pc by 4 and increment outstanding.
REQ-025 SHALL decrement outstanding on every imem_rsp_valid; a response in the request-handshake cycle nets zero change.
REQ-026 SHALL, on a response with discard count nonzero, drop it and decrement the discard count.
REQ-027 SHALL otherwise push {imem_rsp_data, pc of that request, imem_rsp_err} into the FIFO, tracking pc via a separate response-pc register advanced by 4 per kept response.
REQ-028 SHALL present the FIFO head on instr/instr_pc/instr_fault with instr_valid = FIFO not empty; all are combinational from registers.
REQ-029 SHALL pop the head on instr_valid & instr_ready; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-030 SHALL never overflow the FIFO; the credit rule of REQ-021 guarantees space for every kept response.
REQ-031 SHALL, on a kept response with imem_rsp_err = 1, enter HALT: no new requests until redirect.
REQ-032 SHALL, in HALT, still accept and buffer in-flight responses and drain to the decoder.
REQ-033 SHALL, on redirect_valid = 1, in the next cycle:
  - empty the FIFO (a same-cycle pop is void);
  - set fetch_pc and response-pc to {redirect_pc[XLEN-1:2], 2'b00};
  - set discard count to outstanding minus any response arriving that cycle (that response is also dropped);
  - enter RUN.
REQ-034 SHALL give redirect priority over push, pop, and HALT entry in the same cycle.
REQ-035 SHALL wrap fetch_pc modulo 2^XLEN with no fault.
REQ-036 SHALL have latency: redirect cycle N -> request at new pc in cycle N+1; response cycle M -> instr_valid in cycle M+1.

Reset
REQ-037 SHALL, while rst_n = 0:
  - clear FIFO, outstanding, and discard count;
  - set fetch_pc and response-pc to RESET_VECTOR;
  - set state RUN;
  - force imem_req_valid = 0 and instr_valid = 0; instr, instr_pc, instr_fault read 0.
REQ-038 SHALL ignore responses to requests issued before reset.
REQ-039 SHALL raise the first request at the first clk edge after rst_n deasserts.

Verification
REQ-040 SHALL test: reset release, ready = 1, 1-cycle memory returning addr as data, instr_ready = 1 -> instr_pc sequence 0x0, 0x4, 0x8 with instr equal to pc, no bubbles after fill.
REQ-041 SHALL test: instr_ready = 0 with DEPTH = 2 -> exactly 2 requests (0x0, 0x4), then imem_req_valid = 0 until a pop, and the next request is 0x8.
REQ-042 SHALL test: redirect to 0x100 with 2 requests outstanding -> both responses dropped, next instr_pc = 0x100, and no stale entry is visible.
REQ-043 SHALL test: response for 0x8 with imem_rsp_err = 1 -> instr_fault = 1 at pc 0x8, then no requests until redirect to 0x40 resumes fetch at 0x40.
REQ-044 SHALL test: redirect_pc = 0x103 -> fetch at 0x100.
REQ-045 SHALL test: fetch_pc = 0xFFFFFFFC -> next request 0x0.
REQ-046 SHALL test: rst_n asserted mid-burst -> outputs 0 immediately, and fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/cpu_insfetch.sv
// cpu_insfetch: instruction fetch unit with a DEPTH-entry instruction buffer.
// Fetch requests go out in order. In-order responses are buffered and handed
// to the decoder. A redirect flushes the buffer, marks in-flight responses for
// discard and restarts fetch. A kept faulting response halts fetch until the
// next redirect.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   imem_req_valid/ready/addr      fetch request channel (word-aligned addr)
//   imem_rsp_valid/data/err        in-order response channel, always accepted
//   instr_valid/ready, instr,
//   instr_pc, instr_fault          buffer head toward the decoder
//   redirect_valid, redirect_pc    flush and restart fetch
module cpu_insfetch #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int              DEPTH        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  state_e          state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r, rsp_pc_r, redirect_al_s;
  logic [CW-1:0]   outst_r, disc_r, count_r, hs_ext_s, trk_ext_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [31:0]     fifo_instr_r [DEPTH];
  logic [XLEN-1:0] fifo_pc_r    [DEPTH];
  logic            fifo_fault_r [DEPTH];
  logic            req_valid_s, req_hs_s, rsp_tracked_s, keep_s, pop_s;
  logic            fifo_empty_s, credit_ok_s;

  assign redirect_al_s = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_hs_s      = req_valid_s & imem_req_ready;
  // A response with nothing outstanding belongs to a request issued before reset.
  assign rsp_tracked_s = imem_rsp_valid & (outst_r != {CW{1'b0}});
  assign keep_s        = rsp_tracked_s & (disc_r == {CW{1'b0}}) & ~redirect_valid;
  assign fifo_empty_s  = (count_r == {CW{1'b0}});
  assign pop_s         = ~fifo_empty_s & instr_ready & ~redirect_valid;
  assign hs_ext_s      = {{(CW-1){1'b0}}, req_hs_s};
  assign trk_ext_s     = {{(CW-1){1'b0}}, rsp_tracked_s};

  // Credit: every in-flight request, kept or discarded, reserves a buffer slot.
  always_comb begin
    credit_ok_s = (({1'b0, outst_r} + {1'b0, count_r}) < DEPTH_W);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: redirect wins over HALT entry.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = ST_RUN;
    end else if (keep_s && imem_rsp_err) begin
      state_nxt_s = ST_HALT;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM output: request valid, held low in reset and during redirect.
  always_comb begin
    req_valid_s = 1'b0;
    if (rst_n && (state_r == ST_RUN) && !redirect_valid && credit_ok_s) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;

  // Fetch pc, response pc, outstanding and discard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_VECTOR;
      rsp_pc_r   <= RESET_VECTOR;
      outst_r    <= {CW{1'b0}};
      disc_r     <= {CW{1'b0}};
    end else begin
      outst_r <= outst_r + hs_ext_s - trk_ext_s;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_al_s;
        rsp_pc_r   <= redirect_al_s;
        disc_r     <= outst_r - trk_ext_s;
      end else begin
        if (req_hs_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (keep_s) begin
          rsp_pc_r <= rsp_pc_r + PC_STEP;
        end else begin
          rsp_pc_r <= rsp_pc_r;
        end
        if (rsp_tracked_s && (disc_r != {CW{1'b0}})) begin
          disc_r <= disc_r - ONE_C;
        end else begin
          disc_r <= disc_r;
        end
      end
    end
  end

  // Instruction buffer: pointers, occupancy and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_r[i] <= 32'h0;
        fifo_pc_r[i]    <= {XLEN{1'b0}};
        fifo_fault_r[i] <= 1'b0;
      end
    end else if (redirect_valid) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (keep_s) begin
        fifo_instr_r[wr_ptr_r] <= imem_rsp_data;
        fifo_pc_r[wr_ptr_r]    <= rsp_pc_r;
        fifo_fault_r[wr_ptr_r] <= imem_rsp_err;
        wr_ptr_r               <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + {{(CW-1){1'b0}}, keep_s} - {{(CW-1){1'b0}}, pop_s};
    end
  end

  // Head presentation; reads zero whenever the buffer is empty.
  always_comb begin
    instr_valid = ~fifo_empty_s;
    if (fifo_empty_s) begin
      instr       = 32'h0;
      instr_pc    = {XLEN{1'b0}};
      instr_fault = 1'b0;
    end else begin
      instr       = fifo_instr_r[rd_ptr_r];
      instr_pc    = fifo_pc_r[rd_ptr_r];
      instr_fault = fifo_fault_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_cpu_insfetch.sv
// Bench for cpu_insfetch: directed scenarios, a queue-based reference model
// checked every cycle on the falling edge, plus literal expectations.
module tb_cpu_insfetch;
  localparam int DEPTH = 2;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready, instr_fault;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  cpu_insfetch #(.XLEN(32), .RESET_VECTOR(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_fault(instr_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit disc; } infl_t;
  typedef struct { logic [31:0] ins; logic [31:0] pc; logic fault; } ent_t;
  typedef struct { logic [31:0] addr; int due; } memr_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [31:0] m_fetch_pc;
  bit          m_halted;
  infl_t       inflight[$];
  ent_t        mfifo[$];

  // environment state
  memr_t       memq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] hs_log[$];
  ent_t        pop_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  function automatic bit m_req_valid();
    return rst_n && !m_halted && !redirect_valid &&
           ((inflight.size() + mfifo.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_fetch_pc = 32'h0;
    m_halted   = 1'b0;
    inflight.delete();
    mfifo.delete();
  endtask

  // per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req_valid", imem_req_valid, m_req_valid());
      if (m_req_valid()) chk("imem_req_addr", imem_req_addr, m_fetch_pc);
      chk("instr_valid", instr_valid, mfifo.size() > 0);
      if (mfifo.size() > 0) begin
        chk("instr", instr, mfifo[0].ins);
        chk("instr_pc", instr_pc, mfifo[0].pc);
        chk("instr_fault", instr_fault, mfifo[0].fault);
      end else begin
        chk("instr_idle", {instr_fault, instr, instr_pc}, 65'h0);
      end
    end
  end

  // One clock cycle: snapshot inputs, advance model and memory after the edge.
  task automatic tick();
    bit rst, hs, e_hs, e_pop, rv, re, redir;
    logic [31:0] rd, rpc;
    infl_t f;
    #1;
    rst   = rst_n;
    hs    = rst_n && imem_req_valid && imem_req_ready;
    e_hs  = m_req_valid() && imem_req_ready;
    e_pop = (mfifo.size() > 0) && instr_ready && !redirect_valid;
    rv = imem_rsp_valid; rd = imem_rsp_data; re = imem_rsp_err;
    redir = redirect_valid; rpc = redirect_pc;
    if (hs) begin
      hs_log.push_back(imem_req_addr);
      memq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
    end
    if (rst_n && instr_valid && instr_ready && !redirect_valid)
      pop_log.push_back('{ins: instr, pc: instr_pc, fault: instr_fault});
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      model_reset();
    end else if (redir) begin
      mfifo.delete();
      if (rv && inflight.size() > 0) f = inflight.pop_front();
      foreach (inflight[i]) inflight[i].disc = 1'b1;
      m_fetch_pc = {rpc[31:2], 2'b00};
      m_halted   = 1'b0;
    end else begin
      if (e_pop) void'(mfifo.pop_front());
      if (rv && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (!f.disc) begin
          mfifo.push_back('{ins: rd, pc: f.pc, fault: re});
          if (re) m_halted = 1'b1;
        end
      end
      if (e_hs) begin
        inflight.push_back('{pc: m_fetch_pc, disc: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (mfifo.size() > DEPTH) chk("buffer_overflow", mfifo.size(), DEPTH);
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr;
      imem_rsp_err   = err_en && (memq[0].addr == err_addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (4) tick();
    rst_n = 1'b1;
    hs_log.delete();
    pop_log.delete();
    memq.delete();
  endtask

  task automatic wait_hs(input string name, input logic [31:0] exp, input int budget,
                         output int n);
    int n0;
    n0 = hs_log.size();
    n = 0;
    while (hs_log.size() == n0 && n < budget) begin
      tick();
      n++;
    end
    if (hs_log.size() == n0) timeout(name);
    else chk(name, hs_log[n0], exp);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  initial begin
    int n, k;
    bit found;
    logic fault_seen;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_req_valid", imem_req_valid, 1'b0);
    chk("reset_instr_valid", instr_valid, 1'b0);
    chk("reset_instr_fields", {instr_fault, instr, instr_pc}, 65'h0);
    @(posedge clk);
    chk_en = 1'b1;

    // Streaming fetch with a 1-cycle memory returning addr as data.
    mem_lat = 1;
    do_reset();
    wait_hs("first_req_addr", 32'h0, 3, n);
    chk("first_req_latency", n, 1);
    for (k = 0; k < 40 && pop_log.size() < 3; k++) tick();
    if (pop_log.size() < 3) timeout("stream_pops");
    else begin
      for (int i = 0; i < 3; i++) begin
        chk("stream_pc", pop_log[i].pc, 32'(4 * i));
        chk("stream_instr_eq_pc", pop_log[i].ins, pop_log[i].pc);
      end
    end

    // Decoder stalled: the buffer credit stops fetch after two requests.
    instr_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    chk("stall_req_count", hs_log.size(), 2);
    if (hs_log.size() >= 2) begin
      chk("stall_req0", hs_log[0], 32'h0);
      chk("stall_req1", hs_log[1], 32'h4);
    end
    chk("stall_req_valid_low", imem_req_valid, 1'b0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_hs("after_pop_req", 32'h8, 5, n);
    instr_ready = 1'b1;

    // Redirect with two requests outstanding.
    mem_lat = 3;
    do_reset();
    for (k = 0; k < 10 && inflight.size() < 2; k++) tick();
    chk("outstanding_before_redirect", hs_log.size(), 2);
    redirect_to(32'h100);
    pop_log.delete();
    for (k = 0; k < 20 && pop_log.size() < 1; k++) tick();
    if (pop_log.size() < 1) timeout("redirect_first_pop");
    else begin
      chk("redirect_first_pc", pop_log[0].pc, 32'h100);
      chk("redirect_first_instr", pop_log[0].ins, 32'h100);
    end

    // Access fault at 0x8 halts fetch until a redirect.
    mem_lat = 1;
    err_en = 1'b1; err_addr = 32'h8;
    do_reset();
    found = 1'b0; fault_seen = 1'b0;
    for (k = 0; k < 30 && !found; k++) begin
      tick();
      foreach (pop_log[i]) if (pop_log[i].pc == 32'h8) begin
        found = 1'b1; fault_seen = pop_log[i].fault;
      end
    end
    if (!found) timeout("fault_pop");
    else chk("fault_at_0x8", fault_seen, 1'b1);
    n = hs_log.size();
    repeat (6) tick();
    chk("halt_no_requests", hs_log.size(), n);
    err_en = 1'b0;
    redirect_to(32'h40);
    wait_hs("resume_at_0x40", 32'h40, 6, n);

    // Misaligned redirect target is word-aligned.
    repeat (3) tick();
    redirect_to(32'h103);
    wait_hs("aligned_redirect", 32'h100, 6, n);

    // Fetch pc wraps past the top of the address space.
    repeat (3) tick();
    redirect_to(32'hFFFF_FFFC);
    wait_hs("wrap_first", 32'hFFFF_FFFC, 6, n);
    wait_hs("wrap_next", 32'h0, 6, n);

    // Reset asserted mid-burst.
    repeat (5) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_req_valid", imem_req_valid, 1'b0);
    chk("midreset_instr_valid", instr_valid, 1'b0);
    chk("midreset_instr_fields", {instr_fault, instr, instr_pc}, 65'h0);
    repeat (4) tick();
    rst_n = 1'b1;
    hs_log.delete();
    pop_log.delete();
    memq.delete();
    wait_hs("restart_at_reset_vector", 32'h0, 3, n);
    chk("restart_latency", n, 1);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
